// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared states, widths and request type for the SRAM MEM-stage controller
package sram_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACC_LO = 2'd1;
  localparam logic [1:0] ST_ACC_HI = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int SRAM_AW = 18;
  localparam int IDX_W   = SRAM_AW - 1;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

  typedef struct packed {
    logic             wr;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wdata;
  } req_t;

  // Byte address to 32-bit word index; out-of-range addresses wrap.
  function automatic logic [IDX_W-1:0] addr_to_idx(input logic [31:0] addr,
                                                   input logic [31:0] base);
    return IDX_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - per-phase wait-state counter with terminal-count flags
module sram_wait_counter #(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc,
  output logic tc_next
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc      = (cnt_q == CW'(WAIT_STATES));
  // Lets the owner register a strobe that must change on the cycle tc rises.
  assign tc_next = (cnt_d == CW'(WAIT_STATES));

endmodule

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - splits one 32-bit load/store into two 16-bit SRAM phases, stalling via ready
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memReadEn,
  input  logic               memWriteEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  logic [1:0]         state_q, state_d;
  req_t               req_q, req_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               we_n_q, we_n_d;

  logic        req, in_phase, next_in_phase, clr, tc, tc_next, drive;
  logic [15:0] wr_half;

  assign req      = memReadEn | memWriteEn;
  assign in_phase = (state_q == ST_ACC_LO) | (state_q == ST_ACC_HI);
  assign clr      = ~in_phase | tc;

  sram_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .tc      (tc),
    .tc_next (tc_next)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d     = ST_ACC_LO;
          req_d.wr    = memWriteEn;
          req_d.idx   = addr_to_idx(address, ADDR_BASE);
          req_d.wdata = writeData;
          addr_d      = {req_d.idx, 1'b0};
        end
      end
      ST_ACC_LO: begin
        if (tc) begin
          state_d = ST_ACC_HI;
          addr_d  = {req_q.idx, 1'b1};
          if (!req_q.wr) rdata_d[15:0] = SRAM_DQ;
        end
      end
      ST_ACC_HI: begin
        if (tc) begin
          state_d = ST_DONE;
          if (!req_q.wr) rdata_d[31:16] = SRAM_DQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe is released on each phase's final cycle so address stays put around both edges.
  assign next_in_phase = (state_d == ST_ACC_LO) | (state_d == ST_ACC_HI);
  assign we_n_d        = ~(next_in_phase & req_d.wr & ~tc_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
    end
  end

  assign drive   = in_phase & req_q.wr;
  assign wr_half = (state_q == ST_ACC_HI) ? req_q.wdata[31:16] : req_q.wdata[15:0];
  assign SRAM_DQ = drive ? wr_half : 16'hzzzz;

  assign ready     = (state_q == ST_DONE) | ((state_q == ST_IDLE) & ~req);
  assign readData  = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb/tb_sram_mem_controller.sv - scoreboard bench for sram_mem_controller with behavioural SRAM models
module tb_sram_mem_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_rd, a_wr, a_oe, b_rd, b_wr, b_oe;
  logic [31:0] a_addr, a_wd, b_addr, b_wd;
  wire  [31:0] a_rdata, b_rdata;
  wire         a_ready, b_ready, a_we_n, b_we_n;
  wire  [15:0] a_dq, b_dq;
  wire  [17:0] a_saddr, b_saddr;

  logic [15:0] a_mem [0:262143];
  logic [15:0] b_mem [0:262143];

  sram_mem_controller #(.WAIT_STATES(1)) dut_a (
    .clk(clk), .rst(rst), .memReadEn(a_rd), .memWriteEn(a_wr), .address(a_addr),
    .writeData(a_wd), .readData(a_rdata), .ready(a_ready), .SRAM_DQ(a_dq),
    .SRAM_ADDR(a_saddr), .SRAM_WE_N(a_we_n)
  );

  sram_mem_controller #(.WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(rst), .memReadEn(b_rd), .memWriteEn(b_wr), .address(b_addr),
    .writeData(b_wd), .readData(b_rdata), .ready(b_ready), .SRAM_DQ(b_dq),
    .SRAM_ADDR(b_saddr), .SRAM_WE_N(b_we_n)
  );

  // SRAM models: write while strobe is low, drive only when the bench enables a read.
  assign a_dq = (a_oe && a_we_n) ? a_mem[a_saddr] : 16'hzzzz;
  assign b_dq = (b_oe && b_we_n) ? b_mem[b_saddr] : 16'hzzzz;
  always @(posedge clk) if (!a_we_n) a_mem[a_saddr] <= a_dq;
  always @(posedge clk) if (!b_we_n) b_mem[b_saddr] <= b_dq;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd [2];
  int          n_chk, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic snap(input bit sel, output logic rdy, output logic [31:0] rdat,
                      output logic [17:0] sa, output logic wen);
    rdy  = sel ? b_ready : a_ready;
    rdat = sel ? b_rdata : a_rdata;
    sa   = sel ? b_saddr : a_saddr;
    wen  = sel ? b_we_n  : a_we_n;
  endtask

  task automatic access(input bit sel, input string tag, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] load_val, input bit keep);
    int          ws, cyc, n_lo, n_hi, n_we;
    logic [16:0] idx;
    exp_t        e;
    logic        rdy, wen;
    logic [31:0] rdat;
    logic [17:0] sa;
    ws  = sel ? 3 : 1;
    idx = 17'((addr - 32'd1024) >> 2);
    if (!wr) last_rd[sel] = load_val;
    e.rd  = last_rd[sel];
    e.lat = 2 * ws + 3;
    sb_q.push_back(e);
    @(negedge clk);
    if (sel) begin b_rd = rd; b_wr = wr; b_addr = addr; b_wd = wd; b_oe = !wr; end
    else     begin a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wd; a_oe = !wr; end
    #1;
    cyc = 0; n_lo = 0; n_hi = 0; n_we = 0;
    snap(sel, rdy, rdat, sa, wen);
    while (!rdy && cyc < 40) begin
      if (cyc >= 1) begin
        if (sa == {idx, 1'b0}) n_lo++;
        if (sa == {idx, 1'b1}) n_hi++;
        if (!wen) n_we++;
      end
      @(negedge clk); #1;
      cyc++;
      snap(sel, rdy, rdat, sa, wen);
    end
    e = sb_q.pop_front();
    chk({tag, " latency"}, cyc, e.lat);
    chk({tag, " readData"}, rdat, e.rd);
    chk({tag, " addr_lo_cycles"}, n_lo, ws + 1);
    chk({tag, " addr_hi_cycles"}, n_hi, ws + 1);
    chk({tag, " strobe_cycles"}, n_we, wr ? 2 * ws : 0);
    if (wr) begin
      chk({tag, " sram_lo"}, sel ? b_mem[{idx, 1'b0}] : a_mem[{idx, 1'b0}], wd[15:0]);
      chk({tag, " sram_hi"}, sel ? b_mem[{idx, 1'b1}] : a_mem[{idx, 1'b1}], wd[31:16]);
    end
    if (!keep) begin
      if (sel) begin b_rd = 0; b_wr = 0; b_oe = 0; end
      else     begin a_rd = 0; a_wr = 0; a_oe = 0; end
    end
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_oe = 0; a_addr = 0; a_wd = 0;
    b_rd = 0; b_wr = 0; b_oe = 0; b_addr = 0; b_wd = 0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    a_mem[0] = 16'h1234; a_mem[1] = 16'h5678; a_mem[2] = 16'h9ABC; a_mem[3] = 16'hDEF0;
    b_mem[6] = 16'hCAFE; b_mem[7] = 16'hF00D;

    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", a_ready, 1'b1);
    chk("reset readData", a_rdata, 32'h0);
    chk("reset we_n", a_we_n, 1'b1);
    chk("reset sram_addr", a_saddr, 18'h0);
    @(negedge clk); rst = 1'b0;

    access(0, "store", 1, 0, 32'd1032, 32'hDEADBEEF, 32'h0, 0);
    access(0, "load",  0, 1, 32'd1032, 32'h0, 32'hDEADBEEF, 0);
    repeat (3) @(negedge clk);
    #1 chk("load hold", a_rdata, 32'hDEADBEEF);

    access(0, "b2b first",  0, 1, 32'd1024, 32'h0, 32'h5678_1234, 1);
    access(0, "b2b second", 0, 1, 32'd1028, 32'h0, 32'hDEF0_9ABC, 0);
    access(0, "priority",   1, 1, 32'd1027, 32'h0102_0304, 32'h0, 0);

    // Reset in the middle of the high phase of a store.
    @(negedge clk);
    a_wr = 1; a_addr = 32'd1064; a_wd = 32'h5A5A_C3C3; a_oe = 0;
    repeat (3) @(negedge clk);
    #1 chk("mid-store we_n low", a_we_n, 1'b0);
    #1 rst = 1'b1; a_wr = 0; a_oe = 1;
    #1;
    chk("rst mid we_n", a_we_n, 1'b1);
    chk("rst mid ready", a_ready, 1'b1);
    chk("rst mid readData", a_rdata, 32'h0);
    chk("rst mid sram_addr", a_saddr, 18'h0);
    chk("rst mid dq released", a_dq, 16'h0304);
    @(negedge clk); rst = 1'b0; a_oe = 0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;

    access(1, "ws3 load",   0, 1, 32'd1036, 32'h0, 32'hF00D_CAFE, 0);
    access(1, "ws3 store",  1, 0, 32'd1040, 32'h7E57_0A0B, 32'h0, 0);
    access(1, "ws3 reload", 0, 1, 32'd1040, 32'h0, 32'h7E57_0A0B, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
